// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state codes and the owner tag.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_arb_pkg;

    // Arbiter FSM state
    typedef logic arbState_t;
    localparam arbState_t ARB_CPU = 1'b0;
    localparam arbState_t ARB_DMA = 1'b1;

    // Owner of a registered command; also used as the read-return tag
    typedef logic [1:0] owner_t;
    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_CPU  = 2'd1;
    localparam owner_t OWN_DMA  = 2'd2;

endpackage

// File: rtl/dmem_arb_cmd_reg.sv
// Registers the winning command onto the data-memory bus and remembers who owns the pending read.
// Latency: command accepted in cycle N appears on mem_* and the read tag in cycle N+1.
// Backpressure: none; accepts a command every cycle, idle cycles drop write enable and hold address/data.
module dmem_arb_cmd_reg
    import dmem_arb_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmdVld,
    input  logic             cmdWe,
    input  logic [DBITS-1:0] cmdAddr,
    input  logic [DBITS-1:0] cmdWdata,
    input  owner_t           cmdOwner,
    output logic             memWrtEn,
    output logic [DBITS-1:0] memAddr,
    output logic [DBITS-1:0] memDIn,
    output owner_t           rdTag
);

    // Launch the granted command; a reset drops whatever was in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memWrtEn <= 1'b0;
            memAddr  <= '0;
            memDIn   <= '0;
            rdTag    <= OWN_NONE;
        end else begin
            memWrtEn <= cmdVld & cmdWe;
            rdTag    <= (cmdVld && !cmdWe) ? cmdOwner : OWN_NONE;
            if (cmdVld) begin
                memAddr <= cmdAddr;
                memDIn  <= cmdWdata;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU memory stage and the DMA/debug loader.
// Latency: grant is combinational in cycle N; mem_* and read data/rvalid follow in cycle N+1.
// Backpressure: a denied requester holds its command until its gnt; the CPU sees cpu_stall while denied.
// Optional starvation guard for the DMA port: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DBITS      = 32,
    parameter int MAX_BURST  = 8,
    parameter int STARVE_LIM = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [DBITS-1:0] cpu_addr,
    input  logic [DBITS-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [DBITS-1:0] dma_addr,
    input  logic [DBITS-1:0] dma_wdata,
    input  logic             dma_lock,
    output logic             dma_gnt,
    output logic             dma_rvalid,
    output logic [DBITS-1:0] rdata,
    output logic             mem_wrtEn,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_dIn,
    input  logic [DBITS-1:0] mem_dOut
);

    localparam int BW = $clog2(MAX_BURST + 1);
    // A one-beat burst limit means a lock can never extend ownership
    localparam bit CAN_LOCK = (MAX_BURST > 1);

    if (MAX_BURST < 1 || STARVE_LIM < 1) begin : gBadParams
        $error("dmem_arbiter: MAX_BURST and STARVE_LIM must be >= 1");
    end

    arbState_t       state;
    logic [BW-1:0]   burstCnt;
    logic            cpuGnt;
    logic            dmaGnt;
    logic            starveFire;
    logic            cmdVld;
    owner_t          cmdOwner;
    owner_t          rdTag;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_LIM + 1);
    logic [WW-1:0] waitCnt;

    // A DMA request that has waited STARVE_LIM cycles takes one beat from the CPU
    assign starveFire = (state == ARB_CPU) && dma_req && (waitCnt == WW'(STARVE_LIM));

    // Count cycles the DMA request has been refused, saturating at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt <= '0;
        end else if (!dma_req || dmaGnt) begin
            waitCnt <= '0;
        end else if (waitCnt != WW'(STARVE_LIM)) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
`else
    assign starveFire = 1'b0;
`endif

    // Pick at most one winner: forced DMA beat, locked DMA burst, then CPU, then DMA
    always_comb begin
        cpuGnt = 1'b0;
        dmaGnt = 1'b0;
        if (starveFire) begin
            dmaGnt = 1'b1;
        end else if (state == ARB_DMA && dma_req) begin
            dmaGnt = 1'b1;
        end else if (cpu_req) begin
            cpuGnt = 1'b1;
        end else if (dma_req) begin
            dmaGnt = 1'b1;
        end
    end

    // Ownership FSM: a locked DMA grant opens a burst, bounded by MAX_BURST grants in total
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_CPU;
            burstCnt <= '0;
        end else if (state == ARB_CPU) begin
            if (dmaGnt && dma_lock && !starveFire && CAN_LOCK) begin
                state    <= ARB_DMA;
                burstCnt <= BW'(1);
            end
        end else begin
            if (!dmaGnt || !dma_lock || burstCnt == BW'(MAX_BURST - 1)) begin
                state    <= ARB_CPU;
                burstCnt <= '0;
            end else begin
                burstCnt <= burstCnt + 1'b1;
            end
        end
    end

    assign cmdVld   = cpuGnt | dmaGnt;
    assign cmdOwner = dmaGnt ? OWN_DMA : (cpuGnt ? OWN_CPU : OWN_NONE);

    dmem_arb_cmd_reg #(.DBITS(DBITS)) uCmdReg (
        .clk      (clk),
        .reset    (reset),
        .cmdVld   (cmdVld),
        .cmdWe    (dmaGnt ? dma_we : cpu_we),
        .cmdAddr  (dmaGnt ? dma_addr : cpu_addr),
        .cmdWdata (dmaGnt ? dma_wdata : cpu_wdata),
        .cmdOwner (cmdOwner),
        .memWrtEn (mem_wrtEn),
        .memAddr  (mem_addr),
        .memDIn   (mem_dIn),
        .rdTag    (rdTag)
    );

    assign cpu_gnt    = cpuGnt;
    assign dma_gnt    = dmaGnt;
    assign cpu_stall  = cpu_req & ~cpuGnt;
    assign cpu_rvalid = (rdTag == OWN_CPU);
    assign dma_rvalid = (rdTag == OWN_DMA);
    assign rdata      = mem_dOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: checks grants in the issue cycle and mem_*/rvalid/rdata one cycle later.
// Backpressure: requesters hold their command until granted, as the arbiter expects.
module tb_dmem_arbiter;

    localparam int DBITS      = 32;
    localparam int MAX_BURST  = 8;
    localparam int STARVE_LIM = 16;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [DBITS-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic             cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DBITS-1:0] rdata, mem_addr, mem_dIn, mem_dOut;
    logic             mem_wrtEn;

    int vecCount = 0;
    int errCount = 0;

    logic        memLoad;
    logic [31:0] memArr [256];
    logic [31:0] refMem [256];

    dmem_arbiter #(.DBITS(DBITS), .MAX_BURST(MAX_BURST), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .mem_wrtEn(mem_wrtEn), .mem_addr(mem_addr), .mem_dIn(mem_dIn),
        .mem_dOut(mem_dOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Data memory: combinational read, write on the clock edge after mem_wrtEn is seen
    assign mem_dOut = memArr[mem_addr[9:2]];
    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 256; i++) memArr[i] <= initVal(i);
        end else if (mem_wrtEn) begin
            memArr[mem_addr[9:2]] <= mem_dIn;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCpu(input logic r, w, input logic [31:0] a, d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic setDma(input logic r, w, input logic [31:0] a, d, input logic l);
        dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d; dma_lock = l;
    endtask

    task automatic idle();
        setCpu(1'b0, 1'b0, 32'h0, 32'h0);
        setDma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; memLoad = 1'b1; idle();
        tick(); tick();
        @(negedge clk);
        vecCount++;
        if ({mem_wrtEn, cpu_rvalid, dma_rvalid, cpu_gnt, dma_gnt, cpu_stall} !== 6'b0) begin
            errCount++;
            $display("FAIL reset_ctrl: got %b want 000000", {mem_wrtEn, cpu_rvalid, dma_rvalid, cpu_gnt, dma_gnt, cpu_stall});
        end
        vecCount++;
        if (mem_addr !== 32'h0 || mem_dIn !== 32'h0) begin
            errCount++;
            $display("FAIL reset_bus: got addr %h din %h want 0 0", mem_addr, mem_dIn);
        end
        memLoad = 1'b0;
        reset   = 1'b0;
        tick();
    endtask

    task automatic test_cpu_load();
        setCpu(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        vecCount++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errCount++;
            $display("FAIL cpu_load_gnt: got gnt %b dgnt %b stall %b want 1 0 0", cpu_gnt, dma_gnt, cpu_stall);
        end
        tick(); idle();
        @(negedge clk);
        vecCount++;
        if (mem_addr !== 32'h40 || mem_wrtEn !== 1'b0) begin
            errCount++;
            $display("FAIL cpu_load_bus: got addr %h we %b want 40 0", mem_addr, mem_wrtEn);
        end
        vecCount++;
        if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || rdata !== initVal(16) || cpu_stall !== 1'b0) begin
            errCount++;
            $display("FAIL cpu_load_data: got rv %b drv %b rdata %h stall %b want 1 0 %h 0",
                     cpu_rvalid, dma_rvalid, rdata, cpu_stall, initVal(16));
        end
        tick();
    endtask

    task automatic test_both();
        for (int k = 0; k < 3; k++) begin
            setCpu(1'b1, 1'b0, 32'(32'h10 + 4 * k), 32'h0);
            setDma(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
            @(negedge clk);
            vecCount++;
            if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
                errCount++;
                $display("FAIL both_cpu_wins[%0d]: got cgnt %b dgnt %b want 1 0", k, cpu_gnt, dma_gnt);
            end
            tick();
        end
        setCpu(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        vecCount++;
        if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errCount++;
            $display("FAIL both_dma_after: got dgnt %b cgnt %b stall %b want 1 0 0", dma_gnt, cpu_gnt, cpu_stall);
        end
        tick(); idle();
        @(negedge clk);
        vecCount++;
        if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || rdata !== initVal(8)) begin
            errCount++;
            $display("FAIL both_dma_data: got drv %b crv %b rdata %h want 1 0 %h", dma_rvalid, cpu_rvalid, rdata, initVal(8));
        end
        tick();
    endtask

    task automatic test_burst();
        for (int b = 0; b < 9; b++) begin
            setCpu(b > 0, 1'b0, 32'h60, 32'h0);
            setDma(1'b1, 1'b0, 32'(32'h80 + 4 * b), 32'h0, 1'b1);
            @(negedge clk);
            vecCount++;
            if (b < 8) begin
                if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall !== (b > 0)) begin
                    errCount++;
                    $display("FAIL burst_beat[%0d]: got dgnt %b cgnt %b stall %b want 1 0 %b", b, dma_gnt, cpu_gnt, cpu_stall, b > 0);
                end
            end else begin
                if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
                    errCount++;
                    $display("FAIL burst_end: got cgnt %b dgnt %b stall %b want 1 0 0", cpu_gnt, dma_gnt, cpu_stall);
                end
            end
            if (b > 0) begin
                vecCount++;
                if (dma_rvalid !== 1'b1 || rdata !== initVal(32 + b - 1)) begin
                    errCount++;
                    $display("FAIL burst_data[%0d]: got drv %b rdata %h want 1 %h", b, dma_rvalid, rdata, initVal(32 + b - 1));
                end
            end
            tick();
        end
        idle(); tick();
    endtask

    task automatic test_store_load();
        setDma(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        vecCount++;
        if (dma_gnt !== 1'b1) begin
            errCount++;
            $display("FAIL st_ld_dgnt: got %b want 1", dma_gnt);
        end
        tick();
        setDma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        setCpu(1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        vecCount++;
        if (cpu_gnt !== 1'b1 || mem_wrtEn !== 1'b1 || mem_addr !== 32'h100 || mem_dIn !== 32'hDEADBEEF || dma_rvalid !== 1'b0) begin
            errCount++;
            $display("FAIL st_ld_write: got cgnt %b we %b addr %h din %h drv %b want 1 1 100 deadbeef 0",
                     cpu_gnt, mem_wrtEn, mem_addr, mem_dIn, dma_rvalid);
        end
        tick(); idle();
        @(negedge clk);
        vecCount++;
        if (mem_wrtEn !== 1'b0 || cpu_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            errCount++;
            $display("FAIL st_ld_read: got we %b crv %b rdata %h want 0 1 deadbeef", mem_wrtEn, cpu_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        for (int b = 0; b < 3; b++) begin
            setDma(1'b1, 1'b1, 32'(32'h300 + 4 * b), 32'(32'hA0 + b), 1'b1);
            @(negedge clk);
            vecCount++;
            if (dma_gnt !== 1'b1) begin
                errCount++;
                $display("FAIL rst_burst_gnt[%0d]: got %b want 1", b, dma_gnt);
            end
            if (b < 2) tick();
        end
        reset = 1'b1;
        #1;
        vecCount++;
        if (mem_wrtEn !== 1'b0 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || dut.burstCnt !== '0) begin
            errCount++;
            $display("FAIL rst_mid_async: got we %b crv %b drv %b burst %0d want 0 0 0 0",
                     mem_wrtEn, cpu_rvalid, dma_rvalid, dut.burstCnt);
        end
        tick();
        vecCount++;
        if (mem_wrtEn !== 1'b0 || dma_rvalid !== 1'b0) begin
            errCount++;
            $display("FAIL rst_mid_held: got we %b drv %b want 0 0", mem_wrtEn, dma_rvalid);
        end
        reset = 1'b0;
        setCpu(1'b1, 1'b0, 32'h40, 32'h0);
        setDma(1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
        @(negedge clk);
        vecCount++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
            errCount++;
            $display("FAIL rst_mid_state: got cgnt %b dgnt %b want 1 0", cpu_gnt, dma_gnt);
        end
        tick(); idle();
        vecCount++;
        if (memArr[192] !== 32'hA0 || memArr[193] !== initVal(193) || memArr[194] !== initVal(194)) begin
            errCount++;
            $display("FAIL rst_mid_mem: got %h %h %h want 000000a0 %h %h",
                     memArr[192], memArr[193], memArr[194], initVal(193), initVal(194));
        end
        tick();
    endtask

    task automatic test_starve();
        int  dmaCount = 0;
        bit  expD;
        setCpu(1'b1, 1'b0, 32'h44, 32'h0);
        setDma(1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
        for (int k = 0; k < 3 * (STARVE_LIM + 1); k++) begin
            @(negedge clk);
            expD = GUARD && ((k % (STARVE_LIM + 1)) == STARVE_LIM);
            if (dma_gnt === 1'b1) dmaCount++;
            vecCount++;
            if (dma_gnt !== expD || cpu_gnt !== !expD) begin
                errCount++;
                $display("FAIL starve[%0d]: got dgnt %b cgnt %b want %b %b", k, dma_gnt, cpu_gnt, expD, !expD);
            end
            tick();
        end
        vecCount++;
        if (dmaCount != (GUARD ? 3 : 0)) begin
            errCount++;
            $display("FAIL starve_total: got %0d dma grants want %0d", dmaCount, GUARD ? 3 : 0);
        end
        idle(); tick();
    endtask

    // Random traffic. The model tracks who owns the bus and how many beats a locked burst has used,
    // and keeps its own copy of memory to predict read data.
    task automatic test_random();
        bit          inBurst = 0, forced, dReqNow;
        int          burstN = 0, waitN = 0, win;
        bit          cPend = 0, cWe = 0, dPend = 0, dWe = 0, dLock = 0;
        logic [31:0] cAddr = 0, cData = 0, dAddr = 0, dData = 0;
        bit          expWe = 0, expCrv = 0, expDrv = 0;
        logic [31:0] expAddr = 0, expDIn = 0, expRd = 0;

        reset = 1'b1; memLoad = 1'b1; idle();
        tick(); tick();
        reset = 1'b0; memLoad = 1'b0;
        for (int i = 0; i < 256; i++) refMem[i] = initVal(i);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!cPend && $urandom_range(0, 99) < 60) begin
                cPend = 1; cWe = ($urandom_range(0, 2) == 0);
                cAddr = {22'd0, 8'($urandom), 2'b00}; cData = $urandom;
            end
            if (!dPend && $urandom_range(0, 99) < 50) begin
                dPend = 1; dWe = ($urandom_range(0, 2) == 0);
                dAddr = {22'd0, 8'($urandom), 2'b00}; dData = $urandom;
            end
            dLock = ($urandom_range(0, 3) != 0);
            setCpu(cPend, cWe, cAddr, cData);
            setDma(dPend, dWe, dAddr, dData, dLock);
            @(negedge clk);

            // 0 = nobody, 1 = CPU, 2 = DMA
            forced = 0;
            if (inBurst && dPend) win = 2;
            else if (!inBurst && GUARD && waitN == STARVE_LIM && dPend) begin win = 2; forced = 1; end
            else if (cPend) win = 1;
            else if (dPend) win = 2;
            else win = 0;

            vecCount++;
            if (cpu_gnt !== (win == 1) || dma_gnt !== (win == 2) || cpu_stall !== (cPend && win != 1)) begin
                errCount++;
                $display("FAIL rand_gnt[%0d]: got cgnt %b dgnt %b stall %b want %b %b %b",
                         cyc, cpu_gnt, dma_gnt, cpu_stall, win == 1, win == 2, cPend && win != 1);
            end
            vecCount++;
            if (mem_wrtEn !== expWe || mem_addr !== expAddr || mem_dIn !== expDIn) begin
                errCount++;
                $display("FAIL rand_bus[%0d]: got we %b addr %h din %h want %b %h %h",
                         cyc, mem_wrtEn, mem_addr, mem_dIn, expWe, expAddr, expDIn);
            end
            vecCount++;
            if (cpu_rvalid !== expCrv || dma_rvalid !== expDrv || ((expCrv || expDrv) && rdata !== expRd)) begin
                errCount++;
                $display("FAIL rand_read[%0d]: got crv %b drv %b rdata %h want %b %b %h",
                         cyc, cpu_rvalid, dma_rvalid, rdata, expCrv, expDrv, expRd);
            end

            dReqNow = dPend;
            expWe = 0; expCrv = 0; expDrv = 0;
            if (win == 1) begin
                expAddr = cAddr; expDIn = cData;
                if (cWe) begin expWe = 1; refMem[cAddr[9:2]] = cData; end
                else begin expCrv = 1; expRd = refMem[cAddr[9:2]]; end
                cPend = 0;
            end else if (win == 2) begin
                expAddr = dAddr; expDIn = dData;
                if (dWe) begin expWe = 1; refMem[dAddr[9:2]] = dData; end
                else begin expDrv = 1; expRd = refMem[dAddr[9:2]]; end
                dPend = 0;
            end

            if (win == 2) begin
                if (inBurst) begin
                    burstN++;
                    if (!dLock || burstN == MAX_BURST) inBurst = 0;
                end else if (!forced && dLock && MAX_BURST > 1) begin
                    inBurst = 1; burstN = 1;
                end
            end else begin
                inBurst = 0;
            end
            if (dReqNow && win != 2) waitN = (waitN + 1 > STARVE_LIM) ? STARVE_LIM : waitN + 1;
            else waitN = 0;

            tick();
        end
        idle(); tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; memLoad = 1'b1; idle();
        test_reset();
        test_cpu_load();
        test_both();
        test_burst();
        test_store_load();
        test_reset_mid_burst();
        test_starve();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
